// File: rtl/monitor_pkg.sv
// Shared types for the CPU self-test result monitor.
// Status codes are visible on the status output.
package monitor_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PASS    = 2'b01,
        FAIL    = 2'b10,
        TIMEOUT = 2'b11
    } status_t;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/trap_detector.sv
// Flags a CPU halt when the same opcode-fetch address repeats
// TRAP_REPEAT times in a row; halted is valid on the deciding edge.
module trap_detector
    import monitor_pkg::*;
#(
    parameter int TRAP_REPEAT = 3
) (
    input  logic        ph2,
    input  logic        resetb,
    input  logic        enable,
    input  logic        fetch,
    input  logic [15:0] address,
    output logic        halted,
    output logic [15:0] halt_pc
);

    logic [15:0]      prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        if (address == prev) begin
            cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        end
    end

    assign halted  = enable && fetch && (cnt_next == CNT_W'(TRAP_REPEAT));
    assign halt_pc = address;

    // Idle bus cycles leave the repeat history untouched.
    always_ff @(posedge ph2) begin
        if (!resetb) begin
            prev <= 16'h0000;
            cnt  <= '0;
        end else if (enable && fetch) begin
            prev <= address;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/result_monitor.sv
// Watches a CPU self-test: latches the signature byte, detects the final
// self-loop trap or a hang, and reports PASS/FAIL/TIMEOUT.
module result_monitor
    import monitor_pkg::*;
#(
    parameter logic [15:0] RESULT_ADDR    = 16'h0080,
    parameter logic [7:0]  EXPECTED       = 8'h1F,
    parameter int          TIMEOUT_CYCLES = 170,
    parameter int          TRAP_REPEAT    = 3
) (
    input  logic        ph2,
    input  logic        resetb,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    input  logic        memwrite,
    input  logic        fetch,
    output logic [1:0]  status,
    output logic        done,
    output logic [7:0]  result,
    output logic [7:0]  wr_count,
    output logic [15:0] cycles,
    output logic [15:0] trap_pc
);

    status_t     state;
    status_t     state_next;
    logic        run;
    logic        hit;
    logic        halted;
    logic [15:0] halt_pc;
    logic [7:0]  eff_result;
    logic [15:0] cycles_next;

    assign run         = (state == RUN);
    assign hit         = memwrite && (address == RESULT_ADDR);
    // A signature write landing on the trap edge must be the one judged.
    assign eff_result  = hit ? wdata : result;
    assign cycles_next = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

    trap_detector #(
        .TRAP_REPEAT (TRAP_REPEAT)
    ) u_trap (
        .ph2     (ph2),
        .resetb  (resetb),
        .enable  (run),
        .fetch   (fetch),
        .address (address),
        .halted  (halted),
        .halt_pc (halt_pc)
    );

    always_ff @(posedge ph2) begin
        if (!resetb) state <= RUN;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (run) begin
            if (halted) begin
                state_next = (eff_result == EXPECTED) ? PASS : FAIL;
            end else if (cycles_next == 16'(TIMEOUT_CYCLES)) begin
                state_next = TIMEOUT;
            end
        end
    end

    always_comb begin
        status = state;
        done   = !run;
    end

    always_ff @(posedge ph2) begin
        if (!resetb) begin
            result   <= 8'h00;
            wr_count <= 8'h00;
            cycles   <= 16'h0000;
            trap_pc  <= 16'h0000;
        end else if (run) begin
            if (hit) begin
                result   <= wdata;
                wr_count <= (wr_count == 8'hFF) ? wr_count : wr_count + 8'd1;
            end
            cycles <= cycles_next;
            if (halted) trap_pc <= halt_pc;
        end
    end

endmodule

// File: tb/tb_result_monitor.sv
// Directed-vector bench for result_monitor; a second instance with a long
// timeout is used for the write-count saturation case.
module tb_result_monitor;
    import monitor_pkg::*;

    logic        ph2 = 1'b0;
    logic        resetb = 1'b0;
    logic        sat_resetb = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        memwrite = 1'b0;
    logic        fetch = 1'b0;

    logic [1:0]  status, s_status;
    logic        done, s_done;
    logic [7:0]  result, s_result;
    logic [7:0]  wr_count, s_wr_count;
    logic [15:0] cycles, s_cycles;
    logic [15:0] trap_pc, s_trap_pc;

    int checks = 0;
    int errors = 0;

    always #5 ph2 = ~ph2;

    result_monitor dut (
        .ph2      (ph2),
        .resetb   (resetb),
        .address  (address),
        .wdata    (wdata),
        .memwrite (memwrite),
        .fetch    (fetch),
        .status   (status),
        .done     (done),
        .result   (result),
        .wr_count (wr_count),
        .cycles   (cycles),
        .trap_pc  (trap_pc)
    );

    result_monitor #(.TIMEOUT_CYCLES(1000)) dut_sat (
        .ph2      (ph2),
        .resetb   (sat_resetb),
        .address  (address),
        .wdata    (wdata),
        .memwrite (memwrite),
        .fetch    (fetch),
        .status   (s_status),
        .done     (s_done),
        .result   (s_result),
        .wr_count (s_wr_count),
        .cycles   (s_cycles),
        .trap_pc  (s_trap_pc)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d,
                       input logic mw, input logic f);
        @(negedge ph2);
        address  = a;
        wdata    = d;
        memwrite = mw;
        fetch    = f;
        @(posedge ph2);
        #1;
    endtask

    task automatic idle();
        cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        idle();
        resetb = 1'b1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_status"}, 16'(status), 16'(RUN));
        check({tag, "_done"}, 16'(done), 16'd0);
        check({tag, "_result"}, 16'(result), 16'h0000);
        check({tag, "_wrcnt"}, 16'(wr_count), 16'h0000);
        check({tag, "_cycles"}, cycles, 16'h0000);
        check({tag, "_trappc"}, trap_pc, 16'h0000);
    endtask

    initial begin
        idle();
        idle();
        check_cleared("rst");
        resetb = 1'b1;

        // Pass, with idle cycles between the repeated fetches
        cyc(16'h0080, 8'h1F, 1'b1, 1'b0);
        cyc(16'hF010, 8'h00, 1'b0, 1'b1);
        idle();
        cyc(16'hF010, 8'h00, 1'b0, 1'b1);
        idle();
        check("pass_pre_status", 16'(status), 16'(RUN));
        cyc(16'hF010, 8'h00, 1'b0, 1'b1);
        check("pass_status", 16'(status), 16'(PASS));
        check("pass_done", 16'(done), 16'd1);
        check("pass_result", 16'(result), 16'h001F);
        check("pass_trappc", trap_pc, 16'hF010);
        check("pass_cycles", cycles, 16'd6);
        cyc(16'h0080, 8'h55, 1'b1, 1'b0);
        check("frz_result", 16'(result), 16'h001F);
        check("frz_wrcnt", 16'(wr_count), 16'd1);
        check("frz_cycles", cycles, 16'd6);
        check("frz_status", 16'(status), 16'(PASS));
        check("held_sat_wrcnt", 16'(s_wr_count), 16'd0);
        check("held_sat_cycles", s_cycles, 16'd0);

        // Reset after PASS, then 300 signature writes
        do_reset();
        check_cleared("rst_pass");
        sat_resetb = 1'b1;
        for (int i = 0; i < 300; i++) cyc(16'h0080, 8'(i), 1'b1, 1'b0);
        sat_resetb = 1'b0;
        check("sat_wrcnt", 16'(s_wr_count), 16'h00FF);
        check("sat_result", 16'(s_result), 16'h002B);
        check("sat_cycles", s_cycles, 16'd300);
        check("sat_status", 16'(s_status), 16'(RUN));
        check("wto_status", 16'(status), 16'(TIMEOUT));
        check("wto_wrcnt", 16'(wr_count), 16'd170);
        check("wto_result", 16'(result), 16'h00A9);

        // Wrong signature
        do_reset();
        check_cleared("rst_to");
        cyc(16'h0080, 8'h1E, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(16'hF010, 8'h00, 1'b0, 1'b1);
        check("fail_status", 16'(status), 16'(FAIL));
        check("fail_result", 16'(result), 16'h001E);
        check("fail_wrcnt", 16'(wr_count), 16'd1);
        check("fail_done", 16'(done), 16'd1);

        // Hang with ever-changing fetch addresses
        do_reset();
        for (int i = 0; i < 169; i++) cyc(16'h1000 + 16'(i), 8'h00, 1'b0, 1'b1);
        check("to_pre_status", 16'(status), 16'(RUN));
        check("to_pre_cycles", cycles, 16'd169);
        cyc(16'h10A9, 8'h00, 1'b0, 1'b1);
        check("to_status", 16'(status), 16'(TIMEOUT));
        check("to_cycles", cycles, 16'd170);
        check("to_trappc", trap_pc, 16'h0000);
        check("to_done", 16'(done), 16'd1);

        // Signature written on the trap edge itself
        do_reset();
        cyc(16'h0080, 8'h00, 1'b0, 1'b1);
        cyc(16'h0080, 8'h00, 1'b0, 1'b1);
        cyc(16'h0080, 8'h1F, 1'b1, 1'b1);
        check("same_status", 16'(status), 16'(PASS));
        check("same_result", 16'(result), 16'h001F);
        check("same_trappc", trap_pc, 16'h0080);

        // Trap lands on the timeout edge
        do_reset();
        for (int i = 0; i < 167; i++) cyc(16'h1000 + 16'(i), 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(16'hF020, 8'h00, 1'b0, 1'b1);
        check("tie_status", 16'(status), 16'(FAIL));
        check("tie_cycles", cycles, 16'd170);
        check("tie_trappc", trap_pc, 16'hF020);

        // Near-miss addresses never touch the signature
        do_reset();
        cyc(16'h0081, 8'h1F, 1'b1, 1'b0);
        cyc(16'h0180, 8'h1F, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(16'hF030, 8'h00, 1'b0, 1'b1);
        check("miss_wrcnt", 16'(wr_count), 16'd0);
        check("miss_status", 16'(status), 16'(FAIL));
        check("miss_result", 16'(result), 16'h0000);

        // Reset from a terminal state
        do_reset();
        check_cleared("rst_fail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_monitor.md
RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 Parameter RESULT_ADDR, 16'h0080, RAM address holding the test signature byte.
REQ-002 Parameter EXPECTED, 8'h1F, signature value that constitutes a pass.
REQ-003 Parameter TIMEOUT_CYCLES, 170, clock cycles allowed before the test is declared hung.
REQ-004 Parameter TRAP_REPEAT, 3, consecutive identical opcode-fetch addresses that mean the CPU has halted (self-loop trap).
REQ-005 ph2  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetb  input  1  reset, synchronous and active-low.
REQ-007 address  input  16  CPU memory bus address.
REQ-008 wdata  input  8  CPU write data.
REQ-009 memwrite  input  1  high for one cycle per CPU memory write.
REQ-010 fetch  input  1  high when the current bus cycle is an opcode fetch.
REQ-011 status  output  2  monitor state code: RUN, PASS, FAIL or TIMEOUT.
REQ-012 done  output  1  high in PASS, FAIL or TIMEOUT.
REQ-013 result  output  8  last byte written to RESULT_ADDR.
REQ-014 wr_count  output  8  number of writes to RESULT_ADDR, saturating at 8'hFF.
REQ-015 cycles  output  16  cycles spent in RUN, saturating at 16'hFFFF.
REQ-016 trap_pc  output  16  fetch address at which the halt was detected; 0 if no halt.

Function
REQ-017 The FSM SHALL have states RUN, PASS, FAIL and TIMEOUT; RUN is the only non-terminal state.
REQ-018 In RUN, memwrite=1 with address==RESULT_ADDR SHALL load result<=wdata and increment wr_count in the same edge.
REQ-019 In RUN, a fetch SHALL compare address with the previous fetch address; a match increments repeat_cnt and a mismatch sets it to 1.
REQ-020 Cycles with fetch=0 SHALL leave repeat_cnt and the previous fetch address unchanged.
REQ-021 When repeat_cnt reaches TRAP_REPEAT, the FSM SHALL move to PASS if the effective result equals EXPECTED, otherwise FAIL; trap_pc SHALL capture address.
REQ-022 The effective result SHALL include a write to RESULT_ADDR occurring on the same edge as trap detection, so that write's data is compared.
REQ-023 In RUN, cycles SHALL increment every edge; when it would reach TIMEOUT_CYCLES, the FSM SHALL move to TIMEOUT.
REQ-024 If trap detection and timeout occur on the same edge, trap detection SHALL win.
REQ-025 No write ever made to RESULT_ADDR SHALL compare result's reset value 8'h00 against EXPECTED.
REQ-026 Terminal states SHALL hold until reset, with result, wr_count, cycles and trap_pc frozen and bus activity ignored.
REQ-027 Outputs SHALL be registered, with done and status valid one edge after the deciding event.

Reset
REQ-028 resetb=0 on a ph2 edge SHALL set status=RUN, done=0, result=8'h00, wr_count=0, cycles=0, trap_pc=0, repeat_cnt=0, previous fetch address=0.
REQ-029 Reset asserted mid-run or in a terminal state SHALL take effect on the next edge, with no partial state retained.
REQ-030 While resetb=0, no counter SHALL advance and no bus event SHALL be recorded.

Structure
REQ-031 The status enum (RUN=2'b00, PASS=2'b01, FAIL=2'b10, TIMEOUT=2'b11) SHALL reside in shared package monitor_pkg.
REQ-032 Fetch-repeat tracking SHALL be a sub-module trap_detector (inputs ph2, resetb, enable, fetch, address; output halted, halt_pc).
REQ-033 Total RTL target is 120-400 lines.

Verification
REQ-034 Write 8'h1F to 16'h0080, then three fetches at 16'hF010 -> status=PASS, done=1, result=8'h1F, trap_pc=16'hF010.
REQ-035 Write 8'h1E to 16'h0080, then trap -> status=FAIL, result=8'h1E, wr_count=1.
REQ-036 No trap for 170 cycles, fetch addresses always incrementing -> status=TIMEOUT, cycles=170, trap_pc=0.
REQ-037 Third identical fetch at the same edge as a write of 8'h1F to 16'h0080 -> PASS; trap on the same edge as the timeout -> PASS/FAIL, not TIMEOUT.
REQ-038 Writes to 16'h0081 and 16'h0180 only -> wr_count=0; trap yields FAIL with result=8'h00.
REQ-039 resetb pulled low for one cycle after PASS, then 300 writes to 16'h0080 -> all outputs cleared, status=RUN, and wr_count saturates at 8'hFF.
